client_accum_ram: RTL and testbench
===================================

Name: client_accum_ram

Overview:
- Parametrised per-client accumulator memory for the downstream path.
- Stores one D_WIDTH running total per client ID.
- Supports saturating accumulate and overwrite updates at one update per clock, a registered read port, a hardware clear-all sweep, and a limit-crossing alarm per client.
- Sits between the order-cancel event stream and downstream risk logic.

Parameters:
D_WIDTH, 32, width of each client total and update value
A_WIDTH, 5, client ID width
A_MAX, 32, number of entries; must equal 2**A_WIDTH

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
upd_valid  in  1  update request valid
upd_ready  out  1  block can accept an update this cycle
upd_op  in  1  0 = accumulate (saturating add), 1 = overwrite
upd_addr  in  A_WIDTH  client ID to update
upd_data  in  D_WIDTH  value to add or write
clear_all  in  1  request zeroing of every entry
limit  in  D_WIDTH  alarm threshold, sampled when the write-back is computed
rd_addr  in  A_WIDTH  read client ID
rd_data  out  D_WIDTH  registered read data
memwr  out  1  one-cycle pulse: an update write committed on the previous edge
alarm_valid  out  1  one-cycle pulse: a client total crossed limit
alarm_addr  out  A_WIDTH  client ID of the crossing, valid with alarm_valid
busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, rst_n low):
  - rd_data=0, memwr=0, alarm_valid=0, alarm_addr=0, busy=1, upd_ready=0.
  - The pipeline stage is invalidated; an in-flight update is dropped and never written.
  - FSM enters CLEAR with sweep pointer=0. Memory contents are not reset directly; the sweep zeroes them.
- FSM states: CLEAR, IDLE.
  - CLEAR: writes 0 to mem[ptr] each cycle, ptr 0..A_MAX-1, then moves to IDLE. Takes exactly A_MAX cycles. busy=1 throughout. memwr and alarm stay 0. clear_all is ignored.
  - IDLE: busy=0.
  - IDLE with clear_all=1: next state is CLEAR, ptr=0.
- upd_ready = (state==IDLE) && !clear_all.
  - This is combinational from state and clear_all.
  - An update is accepted on an edge where upd_valid && upd_ready.
- Update pipeline (sustains 1 update per cycle):
  - Accept edge E0: capture op, addr and data into stage S1. Issue a synchronous read of mem[upd_addr] (read-first).
  - Forwarding at E0: if S1 is writing the same address at E0, the operand is the value S1 writes at E0, not the stale read.
  - Edge E1:
    - Compute new = op ? data : sat_add(old, data).
    - Write mem[addr] = new.
    - memwr=1 for the cycle after E1.
  - The alarm is also evaluated at E1 (see alarm rule).
- An update in S1 when clear_all is sampled still completes at that edge. The sweep starts writing on the following edge, so no write-port conflict occurs.
- sat_add: D_WIDTH-bit unsigned add. On carry-out the result is all ones (2**D_WIDTH-1). There is no wrap-around.
- Alarm rule:
  - alarm_valid pulses for one cycle after E1 when old < limit && new >= limit, with alarm_addr=addr.
  - Applies to both ops. Staying at or above limit does not re-fire. Dropping below limit and re-crossing does re-fire.
- Read port: rd_data <= mem[rd_addr] every edge, 1-cycle latency.
  - A read colliding with a same-edge write returns the pre-write value.
  - Reads are allowed during CLEAR and return the current contents.
- memwr and alarm_valid deassert on the next edge unless another write or crossing occurs.

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles, upd_ready=0, memwr=0; afterwards busy=0, and reading all addresses returns 0.
- Accumulate addr 3 with 10, then 20, back-to-back -> memwr high two consecutive cycles; read addr 3 returns 30 (forwarding exercised).
- Write addr 7 = 0xFFFFFFF0 (overwrite), then accumulate 0x20 -> read addr 7 returns 0xFFFFFFFF (saturated).
- limit=100; accumulate addr 5 with 60, then 50, then 10 -> alarm_valid exactly once, after the second update, with alarm_addr=5. Then overwrite 0 and accumulate 100 -> alarm fires again.
- Update accepted, clear_all asserted next cycle with upd_valid held -> first update's memwr pulses; upd_ready=0 for the clear_all cycle plus 32 CLEAR cycles; all entries read 0 after.
- rst_n pulsed low mid-sweep and with an update in S1 -> no memwr; the sweep restarts from 0 and lasts the full 32 cycles.

Source files
------------

// File: rtl/client_accum_ram.sv
`default_nettype none
// ============================================================================
// Module   : client_accum_ram
// Purpose  : Per-client running-total memory. It supports saturating
//            accumulate and overwrite updates at one per clock, a registered
//            read port, a clear-all sweep, and a per-client limit-crossing
//            alarm.
// Revision : 1.0 - initial release
// ============================================================================
module client_accum_ram #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_upd_valid,
    output logic               o_upd_ready,
    input  logic               i_upd_op,
    input  logic [A_WIDTH-1:0] i_upd_addr,
    input  logic [D_WIDTH-1:0] i_upd_data,
    input  logic               i_clear_all,
    input  logic [D_WIDTH-1:0] i_limit,
    input  logic [A_WIDTH-1:0] i_rd_addr,
    output logic [D_WIDTH-1:0] o_rd_data,
    output logic               o_memwr,
    output logic               o_alarm_valid,
    output logic [A_WIDTH-1:0] o_alarm_addr,
    output logic               o_busy
);

    localparam logic [A_WIDTH-1:0] c_PTR_LAST = A_WIDTH'(A_MAX - 1);
    localparam logic [D_WIDTH-1:0] c_SAT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [A_WIDTH-1:0] r_ptr;
    logic [A_WIDTH-1:0] w_ptr_next;

    logic [D_WIDTH-1:0] r_mem [0:A_MAX-1];

    // Stage S1: captured update plus its (possibly forwarded) old value
    logic               r_s1_valid;
    logic               r_s1_op;
    logic [A_WIDTH-1:0] r_s1_addr;
    logic [D_WIDTH-1:0] r_s1_data;
    logic [D_WIDTH-1:0] r_s1_old;

    logic               r_memwr;
    logic               r_alarm_valid;
    logic [A_WIDTH-1:0] r_alarm_addr;
    logic [D_WIDTH-1:0] r_rd_data;

    logic               w_accept;
    logic [D_WIDTH:0]   w_sum;
    logic [D_WIDTH-1:0] w_new;
    logic [D_WIDTH-1:0] w_operand;
    logic               w_cross;
    logic               w_we;
    logic [A_WIDTH-1:0] w_waddr;
    logic [D_WIDTH-1:0] w_wdata;

    // State register and sweep pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state logic: the sweep visits every entry once, then idles until clear_all
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        o_busy       = 1'b0;
        o_upd_ready  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_busy     = 1'b1;
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == c_PTR_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                o_upd_ready = !i_clear_all;
                if (i_clear_all) begin
                    w_state_next = ST_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_ptr_next   = '0;
            end
        endcase
    end

    // Write-back value, alarm test, operand forwarding and write-port mux
    always_comb begin
        w_accept  = i_upd_valid && o_upd_ready;
        w_sum     = {1'b0, r_s1_old} + {1'b0, r_s1_data};
        w_new     = r_s1_op ? r_s1_data
                            : (w_sum[D_WIDTH] ? c_SAT_MAX : w_sum[D_WIDTH-1:0]);
        w_cross   = (r_s1_old < i_limit) && (w_new >= i_limit);
        // A back-to-back update to the same client must see S1's result, not the stale entry
        w_operand = (r_s1_valid && (r_s1_addr == i_upd_addr)) ? w_new : r_mem[i_upd_addr];
        w_we      = 1'b0;
        w_waddr   = r_ptr;
        w_wdata   = '0;
        if (r_s1_valid) begin
            w_we    = 1'b1;
            w_waddr = r_s1_addr;
            w_wdata = w_new;
        end else if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
        end
    end

    // Storage array: single write port, no reset (the sweep zeroes it)
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Stage S1 capture; reset drops any in-flight update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
            r_s1_old   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op   <= i_upd_op;
                r_s1_addr <= i_upd_addr;
                r_s1_data <= i_upd_data;
                r_s1_old  <= w_operand;
            end
        end
    end

    // Commit and alarm pulses, one cycle after the write-back edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memwr       <= 1'b0;
            r_alarm_valid <= 1'b0;
            r_alarm_addr  <= '0;
        end else begin
            r_memwr       <= r_s1_valid;
            r_alarm_valid <= r_s1_valid && w_cross;
            if (r_s1_valid && w_cross) begin
                r_alarm_addr <= r_s1_addr;
            end
        end
    end

    // Registered read port, read-first against a same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_memwr       = r_memwr;
    assign o_alarm_valid = r_alarm_valid;
    assign o_alarm_addr  = r_alarm_addr;

endmodule
`default_nettype wire

// File: tb/tb_client_accum_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_client_accum_ram
// Purpose  : Self-checking bench for client_accum_ram against a sequential
//            reference model of the client totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_client_accum_ram;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int AM = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic          upd_op = 1'b0;
    logic [AW-1:0] upd_addr = '0;
    logic [DW-1:0] upd_data = '0;
    logic          clear_all = 1'b0;
    logic [DW-1:0] limit = '1;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          memwr;
    logic          alarm_valid;
    logic [AW-1:0] alarm_addr;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model_mem [AM];

    // Stream stimulus slots and per-sample observed/expected records
    bit            sv_valid [80];
    bit            sv_op    [80];
    logic [AW-1:0] sv_addr  [80];
    logic [DW-1:0] sv_data  [80];
    bit            exp_mw   [82];
    bit            exp_al   [82];
    logic [AW-1:0] exp_aa   [82];
    logic          obs_mw   [82];
    logic          obs_al   [82];
    logic [AW-1:0] obs_aa   [82];

    client_accum_ram #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_upd_valid   (upd_valid),
        .o_upd_ready   (upd_ready),
        .i_upd_op      (upd_op),
        .i_upd_addr    (upd_addr),
        .i_upd_data    (upd_data),
        .i_clear_all   (clear_all),
        .i_limit       (limit),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_memwr       (memwr),
        .o_alarm_valid (alarm_valid),
        .o_alarm_addr  (alarm_addr),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: updates take effect in acceptance order; totals saturate at 2**32-1
    task automatic model_apply(input bit op, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, output bit al);
        longint unsigned old_v, new_v;
        old_v = longint'(model_mem[a]);
        if (op) new_v = longint'(d);
        else begin
            new_v = old_v + longint'(d);
            if (new_v > 64'h0000_0000_FFFF_FFFF) new_v = 64'h0000_0000_FFFF_FFFF;
        end
        al = (old_v < longint'(limit)) && (new_v >= longint'(limit));
        model_mem[a] = new_v[DW-1:0];
    endtask

    task automatic model_clear();
        for (int i = 0; i < AM; i++) model_mem[i] = '0;
    endtask

    task automatic rd(input int a, output logic [DW-1:0] d);
        rd_addr = AW'(a);
        @(posedge clk); #1;
        d = rd_data;
    endtask

    // Drives slots 0..n-1 (one per edge) and records outputs after edges 0..n+1
    task automatic run_stream(input int n);
        bit al;
        for (int k = 0; k <= n + 1; k++) begin
            exp_mw[k] = 1'b0; exp_al[k] = 1'b0; exp_aa[k] = '0;
        end
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n && sv_valid[k]) begin
                upd_valid = 1'b1; upd_op = sv_op[k];
                upd_addr = sv_addr[k]; upd_data = sv_data[k];
                model_apply(sv_op[k], sv_addr[k], sv_data[k], al);
                exp_mw[k+1] = 1'b1; exp_al[k+1] = al; exp_aa[k+1] = sv_addr[k];
            end else begin
                upd_valid = 1'b0;
            end
            @(posedge clk); #1;
            obs_mw[k] = memwr; obs_al[k] = alarm_valid; obs_aa[k] = alarm_addr;
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cnt; bit bad; logic [DW-1:0] d;
        rst_n = 1'b1; #2; rst_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_cmp++; if (upd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", upd_ready); end
        n_cmp++; if (memwr !== 1'b0) begin n_err++; $display("FAIL reset_memwr: got %b want 0", memwr); end
        n_cmp++; if (alarm_valid !== 1'b0 || alarm_addr !== '0) begin n_err++; $display("FAIL reset_alarm: got %b/%0d want 0/0", alarm_valid, alarm_addr); end
        n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        rst_n = 1'b1;
        cnt = 0; bad = 1'b0;
        while (busy === 1'b1 && cnt < 200) begin
            if (memwr !== 1'b0 || upd_ready !== 1'b0) bad = 1'b1;
            @(posedge clk); #1; cnt++;
        end
        n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL reset_sweep_len: got %0d want 32", cnt); end
        n_cmp++; if (bad) begin n_err++; $display("FAIL reset_sweep_quiet: memwr/ready seen high, want low"); end
        for (int a = 0; a < AM; a++) begin
            rd(a, d);
            n_cmp++; if (d !== model_mem[a]) begin n_err++; $display("FAIL reset_read[%0d]: got %h want %h", a, d, model_mem[a]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        sv_valid[0] = 1; sv_op[0] = 0; sv_addr[0] = 3; sv_data[0] = 10;
        sv_valid[1] = 1; sv_op[1] = 0; sv_addr[1] = 3; sv_data[1] = 20;
        run_stream(2);
        for (int k = 0; k <= 3; k++) begin
            n_cmp++; if (obs_mw[k] !== exp_mw[k]) begin n_err++; $display("FAIL b2b_memwr[%0d]: got %b want %b", k, obs_mw[k], exp_mw[k]); end
        end
        rd(3, d);
        n_cmp++; if (d !== 32'd30) begin n_err++; $display("FAIL b2b_read3: got %0d want 30", d); end
    endtask

    task automatic test_saturate();
        logic [DW-1:0] d;
        sv_valid[0] = 1; sv_op[0] = 1; sv_addr[0] = 7; sv_data[0] = 32'hFFFF_FFF0;
        sv_valid[1] = 1; sv_op[1] = 0; sv_addr[1] = 7; sv_data[1] = 32'h20;
        run_stream(2);
        for (int k = 0; k <= 3; k++) begin
            n_cmp++; if (obs_mw[k] !== exp_mw[k] || obs_al[k] !== exp_al[k]) begin n_err++; $display("FAIL sat_pulses[%0d]: got %b/%b want %b/%b", k, obs_mw[k], obs_al[k], exp_mw[k], exp_al[k]); end
        end
        rd(7, d);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_read7: got %h want ffffffff", d); end
    endtask

    task automatic test_alarm();
        int fires;
        limit = 32'd100;
        sv_valid[0] = 1; sv_op[0] = 0; sv_addr[0] = 5; sv_data[0] = 60;
        sv_valid[1] = 1; sv_op[1] = 0; sv_addr[1] = 5; sv_data[1] = 50;
        sv_valid[2] = 1; sv_op[2] = 0; sv_addr[2] = 5; sv_data[2] = 10;
        run_stream(3);
        fires = 0;
        for (int k = 0; k <= 4; k++) begin
            if (obs_al[k] === 1'b1) fires++;
            n_cmp++; if (obs_al[k] !== exp_al[k]) begin n_err++; $display("FAIL alarm1_valid[%0d]: got %b want %b", k, obs_al[k], exp_al[k]); end
        end
        n_cmp++; if (fires != 1) begin n_err++; $display("FAIL alarm1_count: got %0d want 1", fires); end
        n_cmp++; if (obs_al[2] !== 1'b1 || obs_aa[2] !== 5'd5) begin n_err++; $display("FAIL alarm1_addr: got %b/%0d want 1/5", obs_al[2], obs_aa[2]); end
        sv_valid[0] = 1; sv_op[0] = 1; sv_addr[0] = 5; sv_data[0] = 0;
        sv_valid[1] = 1; sv_op[1] = 0; sv_addr[1] = 5; sv_data[1] = 100;
        run_stream(2);
        for (int k = 0; k <= 3; k++) begin
            n_cmp++; if (obs_al[k] !== exp_al[k]) begin n_err++; $display("FAIL alarm2_valid[%0d]: got %b want %b", k, obs_al[k], exp_al[k]); end
        end
        n_cmp++; if (obs_al[2] !== 1'b1 || obs_aa[2] !== 5'd5) begin n_err++; $display("FAIL alarm2_refire: got %b/%0d want 1/5", obs_al[2], obs_aa[2]); end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        for (int r = 0; r < 3; r++) begin
            limit = $urandom_range(800, 50);
            for (int k = 0; k < 40; k++) begin
                sv_valid[k] = ($urandom_range(3, 0) != 0);
                sv_op[k]    = ($urandom_range(3, 0) == 0);
                sv_addr[k]  = AW'($urandom_range(7, 0));
                case ($urandom_range(5, 0))
                    0:       sv_data[k] = $urandom;
                    1:       sv_data[k] = 32'hFFFF_FF00 + $urandom_range(255, 0);
                    default: sv_data[k] = $urandom_range(300, 0);
                endcase
            end
            run_stream(40);
            for (int k = 0; k <= 41; k++) begin
                n_cmp++; if (obs_mw[k] !== exp_mw[k]) begin n_err++; $display("FAIL rand%0d_memwr[%0d]: got %b want %b", r, k, obs_mw[k], exp_mw[k]); end
                n_cmp++; if (obs_al[k] !== exp_al[k]) begin n_err++; $display("FAIL rand%0d_alarm[%0d]: got %b want %b", r, k, obs_al[k], exp_al[k]); end
                if (exp_al[k]) begin
                    n_cmp++; if (obs_aa[k] !== exp_aa[k]) begin n_err++; $display("FAIL rand%0d_alarm_addr[%0d]: got %0d want %0d", r, k, obs_aa[k], exp_aa[k]); end
                end
            end
        end
        for (int a = 0; a < AM; a++) begin
            rd(a, d);
            n_cmp++; if (d !== model_mem[a]) begin n_err++; $display("FAIL rand_read[%0d]: got %h want %h", a, d, model_mem[a]); end
        end
    endtask

    task automatic test_clear_during_update();
        bit al; bit bad; int cnt; logic [DW-1:0] d;
        upd_valid = 1'b1; upd_op = 1'b0; upd_addr = 5'd2; upd_data = 32'd5;
        #1;
        n_cmp++; if (upd_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready_before: got %b want 1", upd_ready); end
        model_apply(1'b0, 5'd2, 32'd5, al);
        @(posedge clk); #1;
        upd_data = 32'd99; clear_all = 1'b1;
        #1;
        n_cmp++; if (upd_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready_clear_cycle: got %b want 0", upd_ready); end
        @(posedge clk); #1;
        clear_all = 1'b0;
        n_cmp++; if (memwr !== 1'b1) begin n_err++; $display("FAIL clr_first_memwr: got %b want 1", memwr); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clr_busy: got %b want 1", busy); end
        cnt = 1; bad = 1'b0;
        while (upd_ready !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1; cnt++;
            if (memwr !== 1'b0) bad = 1'b1;
        end
        upd_valid = 1'b0;
        model_clear();
        n_cmp++; if (cnt != 33) begin n_err++; $display("FAIL clr_not_ready_len: got %0d want 33", cnt); end
        n_cmp++; if (bad) begin n_err++; $display("FAIL clr_sweep_memwr: got 1 want 0"); end
        for (int a = 0; a < AM; a++) begin
            rd(a, d);
            n_cmp++; if (d !== model_mem[a]) begin n_err++; $display("FAIL clr_read[%0d]: got %h want %h", a, d, model_mem[a]); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit bad; int cnt; logic [DW-1:0] d;
        upd_valid = 1'b1; upd_op = 1'b1; upd_addr = 5'd4; upd_data = 32'h1234;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || upd_ready !== 1'b0) begin n_err++; $display("FAIL rst_s1_state: got busy=%b ready=%b want 1/0", busy, upd_ready); end
        bad = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (memwr !== 1'b0) bad = 1'b1;
        end
        rst_n = 1'b1;
        model_clear();
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            @(posedge clk); #1; cnt++;
            if (memwr !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL rst_s1_sweep_len: got %0d want 32", cnt); end
        // Interrupt a fresh sweep partway through
        clear_all = 1'b1;
        @(posedge clk); #1;
        clear_all = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            @(posedge clk); #1; cnt++;
            if (memwr !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL rst_mid_sweep_len: got %0d want 32", cnt); end
        n_cmp++; if (bad) begin n_err++; $display("FAIL rst_memwr: got 1 want 0"); end
        rd(4, d);
        n_cmp++; if (d !== model_mem[4]) begin n_err++; $display("FAIL rst_read4: got %h want %h", d, model_mem[4]); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_saturate();
        test_alarm();
        test_random();
        test_clear_during_update();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
